// File: rtl/fan_mode_sequencer.sv
// Cooling-fan sequencer: synchronises and debounces the temperature level lines,
// runs the mode FSM, soft-ramps the duty and drives the motor PWM and alarm request.
module fan_mode_sequencer #(
    parameter int PWM_PERIOD    = 100000,
    parameter int DUTY_MID      = 50000,
    parameter int STABLE_CYCLES = 50000,
    parameter int RAMP_DIV      = 500,
    parameter int RAMP_STEP     = 1000,
    parameter int CW            = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          temp_in_1,
    input  logic          temp_in_2,
    input  logic          temp_in_3,
    input  logic          alarm_on_off,
    output logic          motor,
    output logic [1:0]    mode,
    output logic [CW-1:0] duty,
    output logic          alarm_req,
    output logic          fault
);

    localparam int QW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [QW-1:0] STABLE_MAX = QW'(STABLE_CYCLES - 1);
    localparam logic [PW-1:0] RAMP_MAX   = PW'(RAMP_DIV - 1);
    localparam logic [CW-1:0] PER_MAX    = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0] PER_FULL   = CW'(PWM_PERIOD);
    localparam logic [CW-1:0] MID_C      = CW'(DUTY_MID);
    localparam logic [CW-1:0] STEP_C     = CW'(RAMP_STEP);
    localparam logic [CW:0]   STEP_EXT   = (CW+1)'(RAMP_STEP);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_LOW   = 3'd1,
        ST_MID   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    logic [2:0]    sync1_q, sync2_q;
    logic [1:0]    raw_s;
    logic [1:0]    cand_q;
    logic [QW-1:0] stab_cnt_q;
    logic          acc_valid_q;
    logic [1:0]    acc_code_q;
    state_t        state_q, state_d;
    logic [1:0]    mode_q;
    logic          fault_q;
    logic          alarm_req_q;
    logic [CW-1:0] target_s;
    logic [CW-1:0] duty_q, duty_d;
    logic [CW:0]   duty_ext_s, tgt_ext_s, up_s;
    logic [PW-1:0] presc_q;
    logic [CW-1:0] pwm_cnt_q;
    logic [CW-1:0] active_q;
    logic          motor_q;

    function automatic logic [1:0] mode_of(input state_t st);
        case (st)
            ST_LOW:  mode_of = 2'd1;
            ST_MID:  mode_of = 2'd2;
            ST_HIGH: mode_of = 2'd3;
            default: mode_of = 2'd0;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous level lines
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {temp_in_3, temp_in_2, temp_in_1};
            sync2_q <= sync1_q;
        end
    end

    // Priority encoder: the coldest asserted line wins
    always_comb begin
        raw_s = 2'd0;
        if (sync2_q[0]) begin
            raw_s = 2'd1;
        end else if (sync2_q[1]) begin
            raw_s = 2'd2;
        end else if (sync2_q[2]) begin
            raw_s = 2'd3;
        end else begin
            raw_s = 2'd0;
        end
    end

    // Stability qualifier; acceptance keeps re-firing while the code stays stable
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q      <= 2'd0;
            stab_cnt_q  <= '0;
            acc_valid_q <= 1'b0;
            acc_code_q  <= 2'd0;
        end else begin
            if (raw_s != cand_q) begin
                cand_q     <= raw_s;
                stab_cnt_q <= '0;
            end else if (stab_cnt_q != STABLE_MAX) begin
                stab_cnt_q <= stab_cnt_q + 1'b1;
            end else begin
                stab_cnt_q <= stab_cnt_q;
            end
            acc_valid_q <= (stab_cnt_q == STABLE_MAX) && (raw_s == cand_q);
            acc_code_q  <= cand_q;
        end
    end

    // Mode next-state: an accepted 0 is a sensor fault except while still in INIT
    always_comb begin
        state_d = state_q;
        if (acc_valid_q) begin
            case (acc_code_q)
                2'd1:    state_d = ST_LOW;
                2'd2:    state_d = ST_MID;
                2'd3:    state_d = ST_HIGH;
                default: state_d = (state_q == ST_INIT) ? ST_INIT : ST_FAULT;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Mode FSM with mode/fault registered alongside the state, alarm one edge later
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            mode_q      <= 2'd0;
            fault_q     <= 1'b0;
            alarm_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_of(state_d);
            fault_q     <= (state_d == ST_FAULT);
            alarm_req_q <= (state_q == ST_HIGH) && !alarm_on_off;
        end
    end

    // Target duty per state; FAULT keeps half cooling as a fail-safe
    always_comb begin
        case (state_q)
            ST_MID:   target_s = MID_C;
            ST_FAULT: target_s = MID_C;
            ST_HIGH:  target_s = PER_FULL;
            default:  target_s = '0;
        endcase
    end

    // One ramp step toward the target, widened by a bit so the sum cannot wrap
    always_comb begin
        duty_ext_s = {1'b0, duty_q};
        tgt_ext_s  = {1'b0, target_s};
        up_s       = duty_ext_s + STEP_EXT;
        duty_d     = duty_q;
        if (duty_q < target_s) begin
            if (up_s >= tgt_ext_s) begin
                duty_d = target_s;
            end else begin
                duty_d = up_s[CW-1:0];
            end
        end else if (duty_q > target_s) begin
            if ((duty_ext_s - tgt_ext_s) <= STEP_EXT) begin
                duty_d = target_s;
            end else begin
                duty_d = duty_q - STEP_C;
            end
        end else begin
            duty_d = duty_q;
        end
    end

    // Free-running ramp prescaler and duty register
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            duty_q  <= '0;
        end else if (presc_q == RAMP_MAX) begin
            presc_q <= '0;
            duty_q  <= duty_d;
        end else begin
            presc_q <= presc_q + 1'b1;
            duty_q  <= duty_q;
        end
    end

    // PWM counter; duty is only picked up at the wrap so no period is cut short
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            active_q  <= '0;
            motor_q   <= 1'b0;
        end else begin
            if (pwm_cnt_q == PER_MAX) begin
                pwm_cnt_q <= '0;
                active_q  <= duty_q;
            end else begin
                pwm_cnt_q <= pwm_cnt_q + 1'b1;
                active_q  <= active_q;
            end
            motor_q <= (pwm_cnt_q < active_q);
        end
    end

    assign motor     = motor_q;
    assign mode      = mode_q;
    assign duty      = duty_q;
    assign alarm_req = alarm_req_q;
    assign fault     = fault_q;

endmodule

// File: doc/fan_mode_sequencer.md
Name: fan_mode_sequencer

Overview:
Sequences the cooling motor from the three Arduino temperature-level lines. It synchronises and debounces the level lines, then runs a mode FSM (INIT/LOW/MID/HIGH/FAULT). It soft-ramps the PWM duty toward the per-mode target and generates the glitch-free motor PWM. It also issues the alarm request that the downstream buzzer/7-seg/RGB display logic consumes.

Parameters:
PWM_PERIOD, 100000, PWM period in clk cycles (2 ms at 50 MHz).
DUTY_MID, 50000, duty for MID and FAULT (50 %).
STABLE_CYCLES, 50000, consecutive identical samples required to accept a new level (1 ms).
RAMP_DIV, 500, clk cycles per ramp tick.
RAMP_STEP, 1000, duty change per ramp tick.
CW, 17, width of duty and PWM counter; must hold PWM_PERIOD.

Ports:
clk  in  1  50 MHz system clock.
rst  in  1  synchronous, active-high reset.
temp_in_1  in  1  level line, temperature < 21 C; asynchronous.
temp_in_2  in  1  level line, 21–23 C; asynchronous.
temp_in_3  in  1  level line, > 23 C; asynchronous.
alarm_on_off  in  1  switch, active-low: 0 = alarm enabled.
motor  out  1  PWM drive to the DC motor.
mode  out  2  0 = INIT/FAULT, 1 = LOW, 2 = MID, 3 = HIGH.
duty  out  CW  current ramped duty value.
alarm_req  out  1  level request to the buzzer tone generator.
fault  out  1  high while in FAULT.

Behaviour:
- Reset, checked at each posedge: all outputs 0; state INIT; synchroniser, qualifier, ramp prescaler, PWM counter and latched duty cleared. Asserting rst mid-operation takes effect on the next edge, overriding everything.
- Sync: each temp_in_x passes through a 2-flop synchroniser. Raw code is priority-encoded: temp_in_1 gives 1, else temp_in_2 gives 2, else temp_in_3 gives 3, else 0.
- Qualifier: keeps a candidate code and a counter.
  - Raw differs from candidate: candidate <= raw, counter <= 0.
  - Otherwise the counter increments, saturating at STABLE_CYCLES-1.
  - The qualified code is accepted when counter == STABLE_CYCLES-1 and raw == candidate.
  - Any shorter glitch is discarded.
- FSM updates the edge after acceptance. Total latency: mode changes on the (STABLE_CYCLES+3)-th rising edge after the first edge at which the new pin level is present.
  - INIT: exits only on an accepted code 1/2/3, to LOW/MID/HIGH. An accepted 0 is ignored in INIT.
  - LOW/MID/HIGH: an accepted code 1/2/3 goes to the corresponding state, any order, direct jumps allowed. An accepted 0 goes to FAULT.
  - FAULT: an accepted 1/2/3 goes to the corresponding state.
  - Re-accepting the current code causes no change.
- Target duty by state: INIT 0, LOW 0, MID DUTY_MID, HIGH PWM_PERIOD, FAULT DUTY_MID (fail-safe cooling).
- Ramp:
  - The prescaler counts 0..RAMP_DIV-1 freely; a tick occurs when it equals RAMP_DIV-1.
  - On a tick, duty moves toward the target by RAMP_STEP, clamped exactly at the target with no overshoot.
  - Duty never exceeds PWM_PERIOD. Compute with CW+1 bits to avoid wrap.
  - A target change mid-ramp redirects from the current duty.
- PWM:
  - The counter runs 0..PWM_PERIOD-1 and wraps to 0.
  - The active duty is latched from duty when the counter == PWM_PERIOD-1, so a period is never truncated.
  - motor <= (counter < active_duty), registered.
  - Active duty 0 gives motor constantly 0; active duty PWM_PERIOD gives motor constantly 1.
- alarm_req <= (state == HIGH) && !alarm_on_off, registered, 1-cycle latency. It drops the edge after leaving HIGH or after the switch opens.
- fault <= (state == FAULT), registered together with mode.

Test Plan:
Shared bench overrides: PWM_PERIOD=20, DUTY_MID=10, STABLE_CYCLES=4, RAMP_DIV=2, RAMP_STEP=5.
1. rst held 3 cycles, then released with all temp_in=0 -> motor, mode, duty, alarm_req and fault are 0 and stay 0 (INIT ignores code 0).
2. temp_in_2=1 from edge E -> mode=2 at edge E+7. Duty then steps 0,5,10 on successive ticks and holds 10. Once the new duty is latched at a PWM wrap, motor is high 10 of every 20 cycles.
3. In MID, temp_in_1 pulsed for 3 cycles -> mode stays 2 and duty stays 10. A 7-cycle pulse -> mode=1 and duty ramps 10,5,0.
4. temp_in_3=1 with alarm_on_off=0 -> mode=3 and alarm_req=1 one edge later. Duty ramps to 20 and motor stays constantly 1 once latched. Setting alarm_on_off=1 drops alarm_req at the next edge.
5. From HIGH, all inputs 0 -> fault=1 and mode=0 at E+7. Duty ramps 20,15,10 and holds. Later temp_in_1=1 -> fault=0, mode=1, duty ramps down to 0.
6. rst pulsed during the ramp at duty=5 -> at the next edge duty=0, motor=0, mode=0. Inputs still at MID give mode=2 again at E+7 after release.
